// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR + R) between NB_REQ requesters.
// Only one burst is in flight at a time; the beat count is checked against len, and a watchdog recovers a hung burst.
module axi_rd_rr_arbiter #(
  parameter  int NB_REQ     = 3,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int ID_WIDTH   = 2,
  parameter  int TIMEOUT    = 1023,
  localparam int IDX_W      = $clog2(NB_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NB_REQ-1:0]            s_ar_valid,
  output logic [NB_REQ-1:0]            s_ar_ready,
  input  logic [NB_REQ*ADDR_WIDTH-1:0] s_ar_addr,
  input  logic [NB_REQ*8-1:0]          s_ar_len,
  input  logic [NB_REQ*ID_WIDTH-1:0]   s_ar_id,
  output logic [NB_REQ-1:0]            s_r_valid,
  input  logic [NB_REQ-1:0]            s_r_ready,
  output logic [DATA_WIDTH-1:0]        s_r_data,
  output logic [1:0]                   s_r_resp,
  output logic                         s_r_last,
  output logic [ID_WIDTH-1:0]          s_r_id,
  output logic                         m_ar_valid,
  input  logic                         m_ar_ready,
  output logic [ADDR_WIDTH-1:0]        m_ar_addr,
  output logic [7:0]                   m_ar_len,
  output logic [ID_WIDTH+IDX_W-1:0]    m_ar_id,
  input  logic                         m_r_valid,
  output logic                         m_r_ready,
  input  logic [DATA_WIDTH-1:0]        m_r_data,
  input  logic [1:0]                   m_r_resp,
  input  logic                         m_r_last,
  input  logic [ID_WIDTH+IDX_W-1:0]    m_r_id,
  output logic [IDX_W-1:0]             grant_o,
  output logic                         busy_o,
  output logic                         err_o,
  output logic                         timeout_o
);

  localparam int               WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int               WD_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [IDX_W:0]   NREQ_W = (IDX_W+1)'(NB_REQ);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(NB_REQ - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [ID_WIDTH-1:0]   id;
  } ar_req_t;

  state_t             state, state_nxt;
  ar_req_t            req_q, ar_in;
  logic [IDX_W-1:0]   rr_ptr, grant, grant_inc, sel, sel_off;
  logic [IDX_W:0]     sel_sum;
  logic               sel_vld, arb_en, ar_hs, r_hs, wd_hit, in_data;
  logic [2*NB_REQ-1:0] vld_dbl;
  logic [NB_REQ-1:0]  vld_rot;
  logic [8:0]         beat_cnt;
  logic [8:0]         len9;
  logic [WD_W-1:0]    wd_cnt;
  logic               unused_rid;

  // Rotate valids so bit 0 is the requester at rr_ptr; the lowest set bit wins.
  assign vld_dbl = {s_ar_valid, s_ar_valid} >> rr_ptr;
  assign vld_rot = vld_dbl[NB_REQ-1:0];

  always_comb begin
    sel_vld = 1'b0;
    sel_off = '0;
    for (int k = NB_REQ - 1; k >= 0; k--) begin
      if (vld_rot[k]) begin
        sel_vld = 1'b1;
        sel_off = IDX_W'(k);
      end
    end
  end

  assign sel_sum   = {1'b0, rr_ptr} + {1'b0, sel_off};
  assign sel       = (sel_sum >= NREQ_W) ? IDX_W'(sel_sum - NREQ_W) : IDX_W'(sel_sum);
  assign grant_inc = (grant == LAST_I) ? '0 : grant + 1'b1;

  // arb_en keeps AR ready low for the first cycle after reset release.
  assign ar_hs   = (state == IDLE) && arb_en && sel_vld;
  assign in_data = (state == DATA);
  assign r_hs    = in_data && m_r_valid && m_r_ready;
  assign wd_hit  = (TIMEOUT != 0) && (state != IDLE) && (wd_cnt == WD_W'(WD_LIM));
  assign len9    = {1'b0, req_q.len};

  always_comb begin
    ar_in      = '0;
    s_ar_ready = '0;
    s_r_valid  = '0;
    m_r_ready  = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (sel == IDX_W'(i)) begin
        ar_in.addr    = s_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ar_in.len     = s_ar_len[i*8 +: 8];
        ar_in.id      = s_ar_id[i*ID_WIDTH +: ID_WIDTH];
        s_ar_ready[i] = ar_hs;
      end
      if (grant == IDX_W'(i)) begin
        s_r_valid[i] = in_data && m_r_valid;
        m_r_ready    = in_data && s_r_ready[i];
      end
    end
  end

  assign m_ar_valid = (state == ADDR);
  assign m_ar_addr  = req_q.addr;
  assign m_ar_len   = req_q.len;
  assign m_ar_id    = {grant, req_q.id};
  assign s_r_data   = in_data ? m_r_data : '0;
  assign s_r_resp   = in_data ? m_r_resp : '0;
  assign s_r_last   = in_data && m_r_last;
  assign s_r_id     = in_data ? m_r_id[ID_WIDTH-1:0] : '0;
  assign grant_o    = grant;
  assign busy_o     = (state != IDLE);
  // Routing relies on the registered grant, so the index bits echoed on R are ignored.
  assign unused_rid = ^m_r_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ar_hs) state_nxt = ADDR;
      ADDR: begin
        if (m_ar_ready)  state_nxt = DATA;
        else if (wd_hit) state_nxt = IDLE;
      end
      DATA: begin
        if (r_hs && m_r_last) state_nxt = IDLE;
        else if (wd_hit)      state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arb_en    <= 1'b0;
      req_q     <= '0;
      rr_ptr    <= '0;
      grant     <= '0;
      beat_cnt  <= '0;
      wd_cnt    <= '0;
      err_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      arb_en <= 1'b1;
      case (state)
        IDLE: begin
          wd_cnt <= '0;
          if (ar_hs) begin
            req_q <= ar_in;
            grant <= sel;
          end
        end
        ADDR: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (m_ar_ready) begin
            beat_cnt <= '0;
          end else if (wd_hit) begin
            timeout_o <= 1'b1;
            rr_ptr    <= grant_inc;
          end
        end
        DATA: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (r_hs) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            // Last too early/late, or a beat beyond len with no last yet.
            if (m_r_last ? (beat_cnt != len9) : (beat_cnt >= len9)) err_o <= 1'b1;
          end
          if (r_hs && m_r_last) begin
            rr_ptr <= grant_inc;
          end else if (wd_hit) begin
            timeout_o <= 1'b1;
            rr_ptr    <= grant_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
